// File: rtl/pwm_deadtime_gen.sv
// Purpose : complementary PWM gate drive with dead-time insertion, compared against a triangular carrier.
// Latency : raw compare rising in cycle N drops pwm_lo at edge N+1 and raises pwm_hi at edge N+1+DEAD_TIME.
// Backpress: duty_ready falls once a duty word is shadowed; it rises again when that word is applied at the next valley.
//
// Ports:
//   clk           single clock, rising-edge
//   reset         asynchronous active-low reset
//   tri_count     triangular carrier 0..MAX_COUNT (holds one extra cycle at each end)
//   enable        0 forces both gate outputs low (via OFF state)
//   duty_in/duty_valid/duty_ready  compare-value handshake
//   pwm_hi/pwm_lo registered high-/low-side gate drives, never both 1
//   period_start  registered one-cycle pulse after each carrier valley
module pwm_deadtime_gen #(
    parameter logic [15:0] MAX_COUNT = 16'd83,
    parameter logic [7:0]  DEAD_TIME = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tri_count,
    input  logic        enable,
    input  logic [15:0] duty_in,
    input  logic        duty_valid,
    output logic        duty_ready,
    output logic        pwm_hi,
    output logic        pwm_lo,
    output logic        period_start
);

    localparam logic [15:0] DUTY_MAX = MAX_COUNT + 16'd1;
    localparam logic [7:0]  DT_LOAD  = DEAD_TIME - 8'd1;
    localparam logic        NO_DT    = (DEAD_TIME == 8'd0);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LO    = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HI    = 3'd3,
        ST_DT_HL = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_dt_cnt;
    logic [7:0]  w_dt_cnt_nxt;
    logic [15:0] r_duty_active;
    logic [15:0] r_shadow;
    logic        r_pending;
    logic [15:0] r_prev_count;
    logic        r_pwm_hi;
    logic        r_pwm_lo;
    logic        r_period_start;

    logic        w_raw;
    logic        w_valley;
    logic        w_handshake;
    logic [15:0] w_duty_clamped;
    logic        w_pwm_hi_nxt;
    logic        w_pwm_lo_nxt;

    // Carrier compare: 0 never drives high, MAX_COUNT+1 always drives high.
    assign w_raw = (tri_count < r_duty_active);

    // Only the first cycle at zero counts; the held second cycle sees prev==0.
    assign w_valley = (tri_count == 16'd0) && (r_prev_count != 16'd0);

    assign duty_ready     = reset && !r_pending;
    assign w_handshake    = duty_valid && duty_ready;
    assign w_duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

    // Duty shadow/active double buffer. A handshake in a valley cycle cannot
    // collide with a load because a load needs pending=1 and a handshake needs
    // pending=0, so a word accepted at a valley waits for the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_duty_active  <= 16'd0;
            r_shadow       <= 16'd0;
            r_pending      <= 1'b0;
            r_prev_count   <= 16'hFFFF;
            r_period_start <= 1'b0;
        end else begin
            r_prev_count   <= tri_count;
            r_period_start <= w_valley;
            if (w_valley && r_pending) begin
                r_duty_active <= r_shadow;
                r_pending     <= 1'b0;
            end else if (w_handshake) begin
                r_shadow  <= w_duty_clamped;
                r_pending <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_OFF;
            r_dt_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_cnt_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_dt_cnt_nxt = r_dt_cnt;
        if (!enable) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (NO_DT) begin
                        w_state_nxt = w_raw ? ST_HI : ST_LO;
                    end else begin
                        w_state_nxt  = w_raw ? ST_DT_LH : ST_DT_HL;
                        w_dt_cnt_nxt = DT_LOAD;
                    end
                end
                ST_LO: begin
                    if (w_raw) begin
                        if (NO_DT) begin
                            w_state_nxt = ST_HI;
                        end else begin
                            w_state_nxt  = ST_DT_LH;
                            w_dt_cnt_nxt = DT_LOAD;
                        end
                    end
                end
                ST_HI: begin
                    if (!w_raw) begin
                        if (NO_DT) begin
                            w_state_nxt = ST_LO;
                        end else begin
                            w_state_nxt  = ST_DT_HL;
                            w_dt_cnt_nxt = DT_LOAD;
                        end
                    end
                end
                // A compare glitch shorter than the dead time aborts back to
                // the side that was already on.
                ST_DT_LH: begin
                    if (!w_raw) begin
                        w_state_nxt = ST_LO;
                    end else if (r_dt_cnt == 8'd0) begin
                        w_state_nxt = ST_HI;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - 8'd1;
                    end
                end
                ST_DT_HL: begin
                    if (w_raw) begin
                        w_state_nxt = ST_HI;
                    end else if (r_dt_cnt == 8'd0) begin
                        w_state_nxt = ST_LO;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // FSM output decode, taken from the next state so the gate flops change
    // on the same edge as the state register.
    always_comb begin
        w_pwm_hi_nxt = (w_state_nxt == ST_HI);
        w_pwm_lo_nxt = (w_state_nxt == ST_LO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_hi <= 1'b0;
            r_pwm_lo <= 1'b0;
        end else begin
            r_pwm_hi <= w_pwm_hi_nxt;
            r_pwm_lo <= w_pwm_lo_nxt;
        end
    end

    assign pwm_hi       = r_pwm_hi;
    assign pwm_lo       = r_pwm_lo;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Purpose : directed self-checking bench for pwm_deadtime_gen (DEAD_TIME=4 main instance, DEAD_TIME=0 side instance).
// Latency : inputs change 1ns after a rising edge, outputs are sampled 1ns after the following edge.
// Backpress: duty handshakes are single-cycle pulses checked against duty_ready.
module tb_pwm_deadtime_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tri_count;
    logic        enable;
    logic [15:0] duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic        pwm_hi;
    logic        pwm_lo;
    logic        period_start;

    logic [15:0] tri_count0;
    logic        enable0;
    logic [15:0] duty_in0;
    logic        duty_valid0;
    logic        duty_ready0;
    logic        pwm_hi0;
    logic        pwm_lo0;
    logic        period_start0;

    int checks = 0;
    int errors = 0;
    int ph     = 0;

    always #5 clk = ~clk;

    pwm_deadtime_gen #(.MAX_COUNT(16'd83), .DEAD_TIME(8'd4)) dut (
        .clk(clk), .reset(reset), .tri_count(tri_count), .enable(enable),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start)
    );

    pwm_deadtime_gen #(.MAX_COUNT(16'd83), .DEAD_TIME(8'd0)) dut0 (
        .clk(clk), .reset(reset), .tri_count(tri_count0), .enable(enable0),
        .duty_in(duty_in0), .duty_valid(duty_valid0), .duty_ready(duty_ready0),
        .pwm_hi(pwm_hi0), .pwm_lo(pwm_lo0), .period_start(period_start0)
    );

    // Carrier phase 0..167: 0,0,1..83,83,82..1
    function automatic logic [15:0] tri_at(input int phase);
        int p;
        p = phase % 168;
        if (p < 2)   return 16'd0;
        if (p <= 84) return 16'(p - 1);
        if (p == 85) return 16'd83;
        return 16'(168 - p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        enable     = 1'b0;
        duty_valid = 1'b0;
        tri_count  = 16'd10;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_in = 16'd0; tri_count = 16'd0;
        enable0 = 1'b0; duty_valid0 = 1'b0; duty_in0 = 16'd0; tri_count0 = 16'd50;
        step();
        step();
        checks++;
        if ({pwm_hi, pwm_lo, period_start} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs: hi/lo/ps=%b expected 000", {pwm_hi, pwm_lo, period_start});
        end
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: duty_ready=%b expected 0", duty_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready: duty_ready=%b expected 1", duty_ready);
        end
    endtask

    // Duty 0 after reset: OFF -> DT_HL for 4 cycles -> LO; first zero is a valley.
    task automatic test_first_period();
        logic [1:0] exp_hl;
        enable = 1'b1;
        for (int k = 0; k < 170; k++) begin
            tri_count = tri_at(ph);
            step();
            exp_hl = (k >= 4) ? 2'b01 : 2'b00;
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL first_period_out k=%0d: hi/lo=%b expected %b", k, {pwm_hi, pwm_lo}, exp_hl);
            end
            checks++;
            if (period_start !== ((ph % 168) == 0)) begin
                errors++; $display("FAIL first_period_ps k=%0d: period_start=%b expected %b", k, period_start, (ph % 168) == 0);
            end
            ph++;
        end
    endtask

    // Duty 42 accepted at phase 50, applied at the next valley.
    task automatic test_duty_update();
        int         p;
        logic [1:0] exp_hl;
        logic       first;
        duty_in = 16'd42;
        for (int n = 0; n < 167; n++) begin
            p = ph % 168;
            tri_count  = tri_at(ph);
            duty_valid = (p == 50);
            step();
            duty_valid = 1'b0;
            checks++;
            if (duty_ready !== (p < 50)) begin
                errors++; $display("FAIL update_ready p=%0d: duty_ready=%b expected %b", p, duty_ready, p < 50);
            end
            checks++;
            if ({pwm_hi, pwm_lo} !== 2'b01) begin
                errors++; $display("FAIL update_pre p=%0d: hi/lo=%b expected 01", p, {pwm_hi, pwm_lo});
            end
            checks++;
            if (period_start !== (p == 0)) begin
                errors++; $display("FAIL update_ps p=%0d: period_start=%b expected %b", p, period_start, p == 0);
            end
            ph++;
        end
        for (int n = 0; n < 210; n++) begin
            p = ph % 168;
            first = (n < 167);
            tri_count = tri_at(ph);
            step();
            exp_hl[1] = (p >= 131) || ((p <= 42) && !(first && (p < 5)));
            exp_hl[0] = (p >= 47) && (p <= 126);
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL duty42 n=%0d p=%0d: hi/lo=%b expected %b", n, p, {pwm_hi, pwm_lo}, exp_hl);
            end
            checks++;
            if (period_start !== (p == 0)) begin
                errors++; $display("FAIL duty42_ps p=%0d: period_start=%b expected %b", p, period_start, p == 0);
            end
            ph++;
        end
    endtask

    // 200 clamps to 84: always high; then duty 0: always low.
    task automatic test_clamp();
        int         p;
        int         k;
        logic       seen;
        logic [1:0] exp_hl;
        do_reset();
        tri_count = 16'd10; duty_in = 16'd200; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++; $display("FAIL clamp_pending: duty_ready=%b expected 0", duty_ready);
        end
        tri_count = 16'd0;
        step();
        checks++;
        if ({duty_ready, period_start} !== 2'b11) begin
            errors++; $display("FAIL clamp_load: ready/ps=%b expected 11", {duty_ready, period_start});
        end
        enable = 1'b1;
        ph = 169;
        for (int n = 0; n < 188; n++) begin
            p = ph % 168;
            tri_count = tri_at(ph);
            step();
            exp_hl = (n >= 4) ? 2'b10 : 2'b00;
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL clamp_hi n=%0d: hi/lo=%b expected %b", n, {pwm_hi, pwm_lo}, exp_hl);
            end
            ph++;
        end
        // Carrier value 100 sits between 84 and 200, so it exposes the clamp.
        tri_count = 16'd100;
        step();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b00) begin
            errors++; $display("FAIL clamp_value: hi/lo=%b expected 00", {pwm_hi, pwm_lo});
        end
        tri_count = 16'd5;
        step();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b10) begin
            errors++; $display("FAIL dt_hl_abort: hi/lo=%b expected 10", {pwm_hi, pwm_lo});
        end
        seen = 1'b0; k = 0; duty_in = 16'd0;
        for (int n = 0; n < 200; n++) begin
            p = ph % 168;
            tri_count  = tri_at(ph);
            duty_valid = (n == 0);
            step();
            duty_valid = 1'b0;
            if (!seen) begin
                checks++;
                if (duty_ready !== (p == 0)) begin
                    errors++; $display("FAIL zero_ready p=%0d: duty_ready=%b expected %b", p, duty_ready, p == 0);
                end
                exp_hl = 2'b10;
                if (p == 0) seen = 1'b1;
            end else begin
                k++;
                exp_hl = (k <= 4) ? 2'b00 : 2'b01;
            end
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL zero_duty n=%0d: hi/lo=%b expected %b", n, {pwm_hi, pwm_lo}, exp_hl);
            end
            ph++;
        end
    endtask

    // Raw pulses of 2 and 4 cycles abort in DT_LH; 5 cycles reach HI.
    task automatic test_short_pulse();
        logic [1:0] exp_hl;
        do_reset();
        tri_count = 16'd50; duty_in = 16'd10; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        tri_count = 16'd0;
        step();
        enable = 1'b1; tri_count = 16'd50;
        for (int n = 0; n < 5; n++) begin
            step();
            exp_hl = (n == 4) ? 2'b01 : 2'b00;
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL pulse_init n=%0d: hi/lo=%b expected %b", n, {pwm_hi, pwm_lo}, exp_hl);
            end
        end
        for (int len = 2; len <= 5; len++) begin
            if (len == 3) continue;
            for (int n = 0; n < len + 2; n++) begin
                tri_count = (n < len) ? 16'd5 : 16'd50;
                step();
                if (n < len) exp_hl = (n == 4) ? 2'b10 : 2'b00;
                else         exp_hl = (len == 5) ? 2'b00 : 2'b01;
                checks++;
                if ({pwm_hi, pwm_lo} !== exp_hl) begin
                    errors++; $display("FAIL pulse len=%0d n=%0d: hi/lo=%b expected %b", len, n, {pwm_hi, pwm_lo}, exp_hl);
                end
            end
        end
        // Leave the block in HI with raw held at 1.
        tri_count = 16'd5;
        for (int n = 0; n < 5; n++) step();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b10) begin
            errors++; $display("FAIL pulse_end: hi/lo=%b expected 10", {pwm_hi, pwm_lo});
        end
    endtask

    task automatic test_enable_drop();
        logic [1:0] exp_hl;
        enable = 1'b0;
        step();
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b00) begin
            errors++; $display("FAIL enable_drop: hi/lo=%b expected 00", {pwm_hi, pwm_lo});
        end
        enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            exp_hl = (n == 4) ? 2'b10 : 2'b00;
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL reenable n=%0d: hi/lo=%b expected %b", n, {pwm_hi, pwm_lo}, exp_hl);
            end
        end
    endtask

    // Reset in DT_LH with a shadowed word pending: the word must be lost.
    task automatic test_reset_mid();
        logic [1:0] exp_hl;
        tri_count = 16'd50;
        for (int n = 0; n < 5; n++) step();
        duty_in = 16'd60; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        checks++;
        if ({duty_ready, pwm_hi, pwm_lo} !== 3'b001) begin
            errors++; $display("FAIL mid_pending: ready/hi/lo=%b expected 001", {duty_ready, pwm_hi, pwm_lo});
        end
        tri_count = 16'd5;
        step();
        reset = 1'b0;
        #2;
        checks++;
        if ({duty_ready, pwm_hi, pwm_lo, period_start} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: ready/hi/lo/ps=%b expected 0000", {duty_ready, pwm_hi, pwm_lo, period_start});
        end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++; $display("FAIL mid_release_ready: duty_ready=%b expected 1", duty_ready);
        end
        for (int n = 0; n < 9; n++) begin
            tri_count = (n == 5) ? 16'd0 : 16'd5;
            step();
            exp_hl = (n >= 4) ? 2'b01 : 2'b00;
            checks++;
            if ({pwm_hi, pwm_lo} !== exp_hl) begin
                errors++; $display("FAIL mid_after n=%0d: hi/lo=%b expected %b", n, {pwm_hi, pwm_lo}, exp_hl);
            end
        end
        reset = 1'b0;
        #2;
        checks++;
        if ({pwm_hi, pwm_lo} !== 2'b00) begin
            errors++; $display("FAIL async_reset: hi/lo=%b expected 00", {pwm_hi, pwm_lo});
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_zero_deadtime();
        logic [1:0] exp_tbl [5];
        exp_tbl = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10};
        tri_count0 = 16'd50; duty_in0 = 16'd10; duty_valid0 = 1'b1;
        step();
        duty_valid0 = 1'b0;
        tri_count0 = 16'd0;
        step();
        for (int n = 0; n < 5; n++) begin
            enable0    = (n != 3);
            tri_count0 = (n == 1 || n == 4) ? 16'd5 : 16'd50;
            step();
            checks++;
            if ({pwm_hi0, pwm_lo0} !== exp_tbl[n]) begin
                errors++; $display("FAIL zero_dt n=%0d: hi/lo=%b expected %b", n, {pwm_hi0, pwm_lo0}, exp_tbl[n]);
            end
        end
    endtask

    // Both-high is illegal at any sample point.
    always @(negedge clk) begin
        if (reset === 1'b1 && pwm_hi === 1'b1 && pwm_lo === 1'b1) begin
            errors++;
            $display("FAIL shoot_through: pwm_hi and pwm_lo both 1 at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_period();
        test_duty_update();
        test_clamp();
        test_short_pulse();
        test_enable_drop();
        test_reset_mid();
        test_zero_deadtime();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
